player_cmd_gen: RTL

//  Command source for the player mover. Turns raw async buttons into the mover's command interface (move_left, move_right, jump, move_enable).
//  - Synchronizes and debounces the buttons on frame ticks.
//  - Issues jump as a request held until the mover acknowledges it via jump_active.
//  - Buffers early jump presses and enforces a landing cooldown.
//  - Sits between the board button pins and the mover; one instance per player.

---
 rtl/player_cmd_gen_pkg.sv | 27 ++
 rtl/player_cmd_gen_btn_debounce.sv | 75 +++++++
 rtl/player_cmd_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/player_cmd_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : player_cmd_gen_pkg
//  Description : Shared definitions for the player command source. Holds the
//                jump FSM state encoding and the default frame constants that
//                the top level and the button debouncer pick up.
//  Revision    : 1.0  initial release
// ============================================================================
package player_cmd_gen_pkg;

    // Jump FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_AIR  = 2'd2,
        ST_COOL = 2'd3
    } jump_state_t;

    // Default frame constants, all counted in SCEN frames.
    localparam int DEF_DB_FRAMES   = 2;
    localparam int DEF_REQ_TIMEOUT = 4;
    localparam int DEF_COOL_FRAMES = 6;
    localparam int DEF_BUF_FRAMES  = 5;
    localparam int DEF_CNT_W       = 4;

endpackage
`default_nettype wire

// File: rtl/player_cmd_gen_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer plus frame-based debouncer for one raw
//                asynchronous button. The synchronizer runs every clk cycle;
//                the debounce counter only advances on tick (SCEN && !pause).
//                A raw level must be seen on DB_FRAMES consecutive ticks
//                before the stable level follows it.
//  Ports       : clk        in  system clock
//                reset      in  asynchronous active-high reset
//                tick       in  debounce evaluation strobe
//                btn_raw    in  raw asynchronous button level
//                level      out registered stable (debounced) level
//                level_next out stable level as it will be after this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_FRAMES = 2,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic level_next
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_FRAMES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (sync2_q != level_q) begin
                // Flip on the tick that would take the count to DB_FRAMES,
                // so the counter itself never exceeds DB_FRAMES-1.
                if (cnt_q == DB_LAST) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign level_next = level_d;

endmodule
`default_nettype wire

// File: rtl/player_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : player_cmd_gen
//  Description : Command source for the player mover. Debounces the three
//                player buttons, applies SOCD-neutral left/right resolution
//                and stun gating, and runs the jump request FSM with a
//                request timeout, an airborne press buffer and a landing
//                cooldown. All commands are registered and only change on an
//                unpaused SCEN cycle.
//  Ports       : clk          in  system clock
//                reset        in  asynchronous active-high reset
//                SCEN         in  one-cycle frame tick shared with the mover
//                btn_left     in  raw async button, active-high
//                btn_right    in  raw async button, active-high
//                btn_jump     in  raw async button, active-high
//                stun         in  suppress new commands
//                pause        in  freeze counters, FSM and move_enable
//                jump_active  in  mover status: airborne
//                move_left    out walk-left command (level)
//                move_right   out walk-right command (level)
//                jump         out jump request, held while requesting
//                move_enable  out mover enable (!pause, every clk)
//  Revision    : 1.0  initial release
// ============================================================================
module player_cmd_gen
    import player_cmd_gen_pkg::*;
#(
    parameter int DB_FRAMES   = DEF_DB_FRAMES,
    parameter int REQ_TIMEOUT = DEF_REQ_TIMEOUT,
    parameter int COOL_FRAMES = DEF_COOL_FRAMES,
    parameter int BUF_FRAMES  = DEF_BUF_FRAMES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic SCEN,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_jump,
    input  logic stun,
    input  logic pause,
    input  logic jump_active,
    output logic move_left,
    output logic move_right,
    output logic jump,
    output logic move_enable
);

    localparam logic [CNT_W-1:0] REQ_LAST  = CNT_W'(REQ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BUF_LAST  = CNT_W'(BUF_FRAMES - 1);
    localparam logic [CNT_W-1:0] BUF_TERM  = CNT_W'(BUF_FRAMES);
    localparam logic [CNT_W-1:0] COOL_LAST =
        CNT_W'((COOL_FRAMES > 0) ? (COOL_FRAMES - 1) : 0);

    logic w_tick;
    logic db_left;
    logic db_left_nx;
    logic db_right;
    logic db_right_nx;
    logic db_jump;
    logic db_jump_nx;
    logic w_jump_edge;
    logic land_decide;

    jump_state_t      state_q;
    jump_state_t      state_d;
    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;
    logic [CNT_W-1:0] ccnt_q;
    logic [CNT_W-1:0] ccnt_d;
    logic [CNT_W-1:0] bcnt_q;
    logic [CNT_W-1:0] bcnt_d;
    logic             buf_q;
    logic             buf_d;
    logic             move_left_q;
    logic             move_left_d;
    logic             move_right_q;
    logic             move_right_d;
    logic             jump_q;
    logic             jump_d;
    logic             move_enable_q;

    assign w_tick = SCEN & ~pause;

    btn_debounce #(.DB_FRAMES(DB_FRAMES), .CNT_W(CNT_W)) u_db_left (
        .clk        (clk),
        .reset      (reset),
        .tick       (w_tick),
        .btn_raw    (btn_left),
        .level      (db_left),
        .level_next (db_left_nx)
    );

    btn_debounce #(.DB_FRAMES(DB_FRAMES), .CNT_W(CNT_W)) u_db_right (
        .clk        (clk),
        .reset      (reset),
        .tick       (w_tick),
        .btn_raw    (btn_right),
        .level      (db_right),
        .level_next (db_right_nx)
    );

    btn_debounce #(.DB_FRAMES(DB_FRAMES), .CNT_W(CNT_W)) u_db_jump (
        .clk        (clk),
        .reset      (reset),
        .tick       (w_tick),
        .btn_raw    (btn_jump),
        .level      (db_jump),
        .level_next (db_jump_nx)
    );

    // level_next only differs from level on a tick, so this is at most one
    // edge per frame and is already qualified by SCEN && !pause.
    assign w_jump_edge = db_jump_nx & ~db_jump;

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        ccnt_d       = ccnt_q;
        bcnt_d       = bcnt_q;
        buf_d        = buf_q;
        move_left_d  = move_left_q;
        move_right_d = move_right_q;
        jump_d       = jump_q;
        land_decide  = 1'b0;

        if (w_tick) begin
            // Outputs use this frame's debounced levels so a press reaches the
            // mover on its next SCEN.
            move_left_d  = db_left_nx  & ~db_right_nx & ~stun;
            move_right_d = db_right_nx & ~db_left_nx  & ~stun;

            // Buffer ageing; the flag is only ever set in AIR and is cleared
            // on every exit from COOL, so this only acts in AIR/COOL.
            if (buf_q) begin
                if (bcnt_q == BUF_LAST) begin
                    buf_d  = 1'b0;
                    bcnt_d = BUF_TERM;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_jump_edge && !stun) begin
                        state_d = ST_REQ;
                        tcnt_d  = '0;
                    end
                end
                ST_REQ: begin
                    // An acknowledged jump wins over stun: the mover is
                    // already airborne, so tracking the landing matters.
                    if (jump_active) begin
                        state_d = ST_AIR;
                    end else if (stun || (tcnt_q == REQ_LAST)) begin
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_AIR: begin
                    // A press in the landing frame is buffered first, so the
                    // post-landing decision below can see it.
                    if (w_jump_edge) begin
                        buf_d  = 1'b1;
                        bcnt_d = '0;
                    end
                    if (!jump_active) begin
                        if (COOL_FRAMES == 0) begin
                            land_decide = 1'b1;
                        end else begin
                            state_d = ST_COOL;
                            ccnt_d  = '0;
                        end
                    end
                end
                ST_COOL: begin
                    if (ccnt_q == COOL_LAST) begin
                        land_decide = 1'b1;
                    end else begin
                        ccnt_d = ccnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (land_decide) begin
                state_d = (buf_d && !stun) ? ST_REQ : ST_IDLE;
                tcnt_d  = '0;
                buf_d   = 1'b0;
                bcnt_d  = '0;
            end

            jump_d = (state_d == ST_REQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tcnt_q        <= '0;
            ccnt_q        <= '0;
            bcnt_q        <= '0;
            buf_q         <= 1'b0;
            move_left_q   <= 1'b0;
            move_right_q  <= 1'b0;
            jump_q        <= 1'b0;
            move_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            ccnt_q        <= ccnt_d;
            bcnt_q        <= bcnt_d;
            buf_q         <= buf_d;
            move_left_q   <= move_left_d;
            move_right_q  <= move_right_d;
            jump_q        <= jump_d;
            move_enable_q <= ~pause;
        end
    end

    assign move_left   = move_left_q;
    assign move_right  = move_right_q;
    assign jump        = jump_q;
    assign move_enable = move_enable_q;

endmodule
`default_nettype wire
